sr_drive_ctrl: RTL and testbench
================================

Name: sr_drive_ctrl

Overview:
Upstream driver for the team's NOR SR latch. Takes two raw, bouncy push-button inputs (set request, reset request), synchronises and debounces them, and converts them into clean, mutually exclusive, fixed-width S/R pulses. The latch never receives S=R=1 and never sees glitches. Also keeps a shadow copy of the state the latch is expected to hold.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced level changes; legal range 1..255.
PULSE_CYCLES, 2, width in CLK cycles of each S or R pulse; legal range 1..15.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
SET_BTN  input  1  raw, asynchronous set request.
CLR_BTN  input  1  raw, asynchronous reset request.
S  output  1  set drive to latch; registered.
R  output  1  reset drive to latch; registered.
BUSY  output  1  a pulse or gap cycle is in progress.
Q_EXP  output  1  expected latch Q after the last completed pulse.
Q_VALID  output  1  high once at least one pulse has completed since reset.
CONFLICT  output  1  one-cycle flag: both requests rose in the same cycle.
CONFLICT_CNT  output  8  saturating count of conflicts; see Optional Feature.

Behaviour:
- Reset: one clock, CLK. RST is asynchronous and active-high. While RST=1, every flop clears: sync chains 0, debounced levels 0, counters 0, state IDLE. Outputs S=R=BUSY=Q_EXP=Q_VALID=CONFLICT=0 and CONFLICT_CNT=0.
- Reset mid-pulse: S/R fall immediately, without waiting for a clock edge. Pending requests are discarded.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce, per channel:
  - An 8-bit counter increments while the sync output differs from the debounced level.
  - It clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles at the next edge and the counter clears.
- Request: a debounced 0->1 transition produces a one-cycle request. Falling edges produce nothing.
- Latency: take edge 1 as the first edge that samples the raw input high, with the input held stable. S (or R) is first high after edge DEBOUNCE_CYCLES+3.
- Pending: one-deep pending flag per channel.
  - A request arriving while BUSY sets the flag.
  - A repeat while the flag is already set is dropped.
- FSM states: IDLE, SET_P, CLR_P, GAP.
  - IDLE: if CLR request or CLR pending, go to CLR_P; otherwise if SET request or SET pending, go to SET_P. Clear the consumed pending flag.
  - SET_P / CLR_P: S (or R) is held high for exactly PULSE_CYCLES cycles using a 4-bit counter, then the FSM goes to GAP.
  - GAP: exactly one cycle with S=R=0, then back to IDLE.
  - Back-to-back pulses are therefore always separated by at least one cycle with both outputs low.
- Priority: reset wins.
  - If both requests rise in the same cycle, only the R pulse is issued and the SET request is dropped.
  - CONFLICT pulses high for that one cycle.
- Shadow state: on the cycle an S pulse ends, Q_EXP<=1 and Q_VALID<=1. An R pulse ending sets Q_EXP<=0 and Q_VALID<=1.
- BUSY is high in SET_P, CLR_P and GAP.
- Invariant: S&R is never 1, in any cycle, under any stimulus.

Optional Feature:
Macro SR_DRIVE_CONFLICT_CNT_EN.
- Defined: CONFLICT_CNT increments on every CONFLICT pulse and saturates at 255. It clears only on RST.
- Undefined: the counter logic is not built and CONFLICT_CNT is tied to 8'd0.
- The port exists in both builds.

Decomposition:
- Shared package sr_ctrl_pkg: FSM state encodings (IDLE=2'd0, SET_P=2'd1, CLR_P=2'd2, GAP=2'd3) and the constant DB_CNT_W=8.
- One natural sub-module, sr_debounce: synchroniser, debounce counter and rising-edge request output. It has parameter DEBOUNCE_CYCLES and is instantiated twice.
- The FSM, pending flags, shadow state and conflict logic live in the top level.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2 unless noted):
1. Release RST, hold SET_BTN=1 from edge 1 -> S=1 after edges 7 and 8, S=0 after edge 9; Q_EXP=1, Q_VALID=1; R stays 0.
2. SET_BTN high for 3 cycles then low (bounce) -> no S pulse; BUSY, Q_VALID and Q_EXP remain 0.
3. SET_BTN and CLR_BTN rise on the same edge -> R pulses for 2 cycles, S never rises; CONFLICT high for 1 cycle; Q_EXP=0; CONFLICT_CNT=1 with the macro defined, 0 without.
4. CLR pulse in progress and a SET request arrives -> R runs its full 2 cycles, then 1 GAP cycle with S=R=0, then S for 2 cycles; final Q_EXP=1.
5. Assert RST asynchronously midway through an S pulse -> S falls before the next CLK edge; all outputs 0; the pending request is not served after release.
6. Random button bouncing for 10k cycles with PULSE_CYCLES=1 -> an assertion confirms S&R==0 every cycle and a GAP cycle between any two pulses.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch drive controller: FSM encodings and
// debounce counter width.
package sr_ctrl_pkg;

    localparam int DB_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debouncer and a
// one-cycle registered request on each debounced rising edge.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic req_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0] CNT_ZERO = {DB_CNT_W{1'b0}};
    localparam logic [DB_CNT_W-1:0] CNT_ONE  = {{(DB_CNT_W-1){1'b0}}, 1'b1};

    logic                sync1_q, sync2_q;
    logic                level_q, level_d;
    logic                req_q, req_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for the debounce counter, debounced level and request
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        req_d   = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = CNT_ZERO;
            req_d   = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser and debounce state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced push-button driver producing mutually exclusive, fixed-width S/R
// pulses for a NOR SR latch. Define SR_DRIVE_CONFLICT_CNT_EN to build the
// saturating conflict counter; otherwise CONFLICT_CNT reads 0.
module sr_drive_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SET_BTN,
    input  logic       CLR_BTN,
    output logic       S,
    output logic       R,
    output logic       BUSY,
    output logic       Q_EXP,
    output logic       Q_VALID,
    output logic       CONFLICT,
    output logic [7:0] CONFLICT_CNT
);

    localparam logic [3:0] PCNT_LAST = 4'(PULSE_CYCLES - 1);

    logic       set_req_s, clr_req_s, conflict_s, set_ok_s;
    sr_state_e  state_q;
    logic [3:0] pcnt_q;
    logic       s_q, r_q, busy_q, q_exp_q, q_valid_q, conflict_q;
    logic       set_pend_q, clr_pend_q;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk_i (CLK),
        .rst_i (RST),
        .btn_i (SET_BTN),
        .req_o (set_req_s)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk_i (CLK),
        .rst_i (RST),
        .btn_i (CLR_BTN),
        .req_o (clr_req_s)
    );

    // A simultaneous set is dropped in favour of the clear
    assign conflict_s = set_req_s & clr_req_s;
    assign set_ok_s   = set_req_s & ~clr_req_s;

    // Pulse FSM with pending flags, shadow state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pcnt_q     <= 4'd0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            q_exp_q    <= 1'b0;
            q_valid_q  <= 1'b0;
            conflict_q <= 1'b0;
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            conflict_q <= conflict_s;
            case (state_q)
                IDLE: begin
                    if (clr_req_s || clr_pend_q) begin
                        state_q    <= CLR_P;
                        r_q        <= 1'b1;
                        busy_q     <= 1'b1;
                        pcnt_q     <= 4'd0;
                        clr_pend_q <= 1'b0;
                        if (set_ok_s) begin
                            set_pend_q <= 1'b1;
                        end
                    end else if (set_ok_s || set_pend_q) begin
                        state_q    <= SET_P;
                        s_q        <= 1'b1;
                        busy_q     <= 1'b1;
                        pcnt_q     <= 4'd0;
                        set_pend_q <= 1'b0;
                    end
                end
                SET_P, CLR_P: begin
                    if (set_ok_s) begin
                        set_pend_q <= 1'b1;
                    end
                    if (clr_req_s) begin
                        clr_pend_q <= 1'b1;
                    end
                    if (pcnt_q == PCNT_LAST) begin
                        state_q   <= GAP;
                        s_q       <= 1'b0;
                        r_q       <= 1'b0;
                        q_exp_q   <= (state_q == SET_P);
                        q_valid_q <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q + 4'd1;
                    end
                end
                GAP: begin
                    if (set_ok_s) begin
                        set_pend_q <= 1'b1;
                    end
                    if (clr_req_s) begin
                        clr_pend_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRIVE_CONFLICT_CNT_EN
    logic [7:0] ccnt_q;

    // Saturating conflict counter, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ccnt_q <= 8'd0;
        end else if (conflict_s && (ccnt_q != 8'd255)) begin
            ccnt_q <= ccnt_q + 8'd1;
        end
    end

    assign CONFLICT_CNT = ccnt_q;
`else
    assign CONFLICT_CNT = 8'd0;
`endif

    assign S        = s_q;
    assign R        = r_q;
    assign BUSY     = busy_q;
    assign Q_EXP    = q_exp_q;
    assign Q_VALID  = q_valid_q;
    assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2) plus a
// second PULSE_CYCLES=1 instance driven by random bouncing buttons.
module tb_sr_drive_ctrl;

    logic       CLK = 1'b0;
    logic       RST, SET_BTN, CLR_BTN;
    logic       S, R, BUSY, Q_EXP, Q_VALID, CONFLICT;
    logic [7:0] CONFLICT_CNT;

    logic       rst2, set2, clr2;
    logic       s2, r2, busy2, qexp2, qval2, conf2;
    logic [7:0] ccnt2;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SR_DRIVE_CONFLICT_CNT_EN
    localparam int EXP_CCNT = 1;
`else
    localparam int EXP_CCNT = 0;
`endif

    always #5 CLK = ~CLK;

    sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) u_dut (
        .CLK(CLK), .RST(RST), .SET_BTN(SET_BTN), .CLR_BTN(CLR_BTN),
        .S(S), .R(R), .BUSY(BUSY), .Q_EXP(Q_EXP), .Q_VALID(Q_VALID),
        .CONFLICT(CONFLICT), .CONFLICT_CNT(CONFLICT_CNT)
    );

    sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1)) u_dut2 (
        .CLK(CLK), .RST(rst2), .SET_BTN(set2), .CLR_BTN(clr2),
        .S(s2), .R(r2), .BUSY(busy2), .Q_EXP(qexp2), .Q_VALID(qval2),
        .CONFLICT(conf2), .CONFLICT_CNT(ccnt2)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        SET_BTN = 1'b0;
        CLR_BTN = 1'b0;
        RST     = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Invariant monitor: never S&R, and with 1-cycle pulses any two pulses
    // must be separated by a low cycle.
    int  inv_viol = 0;
    int  pulses2  = 0;
    logic ps1 = 1'b0, pr1 = 1'b0, ps2 = 1'b0, pr2 = 1'b0;
    always @(negedge CLK) begin
        if (S && R) inv_viol++;
        if (s2 && r2) inv_viol++;
        if ((ps1 && R) || (pr1 && S)) inv_viol++;
        if ((ps2 || pr2) && (s2 || r2)) inv_viol++;
        if ((s2 || r2) && !(ps2 || pr2)) pulses2++;
        ps1 = S; pr1 = R; ps2 = s2; pr2 = r2;
    end

    logic s_tr [0:31];
    logic r_tr [0:31];
    int   cnt_s, cnt_r, cnt_b, first_s, last_r;

    initial begin
        rst2 = 1'b1; set2 = 1'b0; clr2 = 1'b0;
        SET_BTN = 1'b0; CLR_BTN = 1'b0; RST = 1'b1;
        tick();
        tick();
        check_eq("rst_S", S, 0);
        check_eq("rst_R", R, 0);
        check_eq("rst_BUSY", BUSY, 0);
        check_eq("rst_QEXP", Q_EXP, 0);
        check_eq("rst_QVALID", Q_VALID, 0);
        check_eq("rst_CONFLICT", CONFLICT, 0);
        check_eq("rst_CCNT", CONFLICT_CNT, 0);
        RST = 1'b0;
        rst2 = 1'b0;

        // 1: held set button -> S after edges 7,8, low after 9
        tick();
        SET_BTN = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            s_tr[e] = S;
            r_tr[e] = R;
            if (e == 9) begin
                check_eq("t1_qexp_e9", Q_EXP, 1);
                check_eq("t1_qvalid_e9", Q_VALID, 1);
                check_eq("t1_busy_gap", BUSY, 1);
            end
            if (e == 10) check_eq("t1_busy_idle", BUSY, 0);
        end
        check_eq("t1_S_e6", s_tr[6], 0);
        check_eq("t1_S_e7", s_tr[7], 1);
        check_eq("t1_S_e8", s_tr[8], 1);
        check_eq("t1_S_e9", s_tr[9], 0);
        cnt_r = 0;
        for (int e = 1; e <= 12; e++) cnt_r += int'(r_tr[e]);
        check_eq("t1_R_never", cnt_r, 0);
        SET_BTN = 1'b0;
        cnt_s = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt_s += int'(S);
        end
        check_eq("t1_fall_no_pulse", cnt_s, 0);
        check_eq("t1_qexp_hold", Q_EXP, 1);

        // 2: 3-cycle bounce is rejected
        do_reset();
        SET_BTN = 1'b1;
        tick(); tick(); tick();
        SET_BTN = 1'b0;
        cnt_s = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt_s += int'(S);
            cnt_b += int'(BUSY);
        end
        check_eq("t2_no_S", cnt_s, 0);
        check_eq("t2_no_busy", cnt_b, 0);
        check_eq("t2_qvalid", Q_VALID, 0);
        check_eq("t2_qexp", Q_EXP, 0);

        // 3: simultaneous rise -> R only, one conflict cycle
        do_reset();
        SET_BTN = 1'b1;
        CLR_BTN = 1'b1;
        cnt_s = 0; cnt_b = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            s_tr[e] = S;
            r_tr[e] = R;
            cnt_s += int'(S);
            cnt_b += int'(CONFLICT);
            if (e == 7) check_eq("t3_conflict_e7", CONFLICT, 1);
        end
        check_eq("t3_R_e7", r_tr[7], 1);
        check_eq("t3_R_e8", r_tr[8], 1);
        check_eq("t3_R_e9", r_tr[9], 0);
        check_eq("t3_no_S", cnt_s, 0);
        check_eq("t3_conflict_cycles", cnt_b, 1);
        check_eq("t3_qexp", Q_EXP, 0);
        check_eq("t3_qvalid", Q_VALID, 1);
        check_eq("t3_ccnt", CONFLICT_CNT, EXP_CCNT);
        SET_BTN = 1'b0;
        CLR_BTN = 1'b0;

        // 4: set request during a clear pulse is queued behind it
        do_reset();
        CLR_BTN = 1'b1;
        tick();
        SET_BTN = 1'b1;
        s_tr[1] = S;
        r_tr[1] = R;
        for (int e = 2; e <= 24; e++) begin
            tick();
            s_tr[e] = S;
            r_tr[e] = R;
        end
        check_eq("t4_R_e7", r_tr[7], 1);
        check_eq("t4_R_e8", r_tr[8], 1);
        check_eq("t4_R_e9", r_tr[9], 0);
        cnt_s = 0; cnt_r = 0; first_s = 0; last_r = 0;
        for (int e = 1; e <= 24; e++) begin
            cnt_s += int'(s_tr[e]);
            cnt_r += int'(r_tr[e]);
            if (r_tr[e]) last_r = e;
            if (s_tr[e] && first_s == 0) first_s = e;
        end
        check_eq("t4_R_width", cnt_r, 2);
        check_eq("t4_S_width", cnt_s, 2);
        check_eq("t4_gap_1or2", int'((first_s - last_r - 1) >= 1 && (first_s - last_r - 1) <= 2), 1);
        check_eq("t4_S_contig", int'(s_tr[first_s + 1]), 1);
        check_eq("t4_qexp", Q_EXP, 1);
        SET_BTN = 1'b0;
        CLR_BTN = 1'b0;

        // 5: async reset mid S pulse with a clear pending
        do_reset();
        SET_BTN = 1'b1;
        tick();
        CLR_BTN = 1'b1;
        for (int e = 2; e <= 8; e++) tick();
        check_eq("t5_S_before_rst", S, 1);
        check_eq("t5_R_before_rst", R, 0);
        #2;
        RST = 1'b1;
        SET_BTN = 1'b0;
        CLR_BTN = 1'b0;
        #1;
        check_eq("t5_S_async", S, 0);
        check_eq("t5_busy_async", BUSY, 0);
        check_eq("t5_qvalid_async", Q_VALID, 0);
        tick();
        RST = 1'b0;
        cnt_s = 0; cnt_r = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            cnt_s += int'(S);
            cnt_r += int'(R);
        end
        check_eq("t5_no_R_after", cnt_r, 0);
        check_eq("t5_no_S_after", cnt_s, 0);

        // 6: random bouncing on the 1-cycle-pulse instance
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7, 0) == 0) set2 = ~set2;
            if ($urandom_range(7, 0) == 0) clr2 = ~clr2;
            tick();
        end
        check_eq("t6_invariant_viol", inv_viol, 0);
        check_eq("t6_activity", int'(pulses2 > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
